// File: rtl/adc_sampler_if.sv
// ---------------------------------------------------------------------------
// adc_sampler_if
// Groups the serial ADC bus and the sample stream handshake of adc_sampler.
//   adc_clk      : divided serial clock towards the ADC
//   adc_conv     : conversion strobe towards the ADC
//   adc_data     : serial data returned by the ADC, MSB first
//   sample_data  : extracted sample towards the consumer
//   sample_valid : sample_data holds an undelivered sample
//   sample_ready : consumer accepts the sample
// master = the sampler side, slave = ADC plus consumer side.
// ---------------------------------------------------------------------------
interface adc_sampler_if #(
    parameter int OUT_BITS = 8
) ();
    logic                adc_clk;
    logic                adc_conv;
    logic                adc_data;
    logic [OUT_BITS-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output adc_clk,
        output adc_conv,
        input  adc_data,
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  adc_clk,
        input  adc_conv,
        output adc_data,
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_sampler.sv
// ---------------------------------------------------------------------------
// adc_sampler
// Drives a serial ADC: raises adc_conv for CONV_CYCLES adc_clk periods, then
// clocks in a FRAME_BITS frame (MSB first), extracts OUT_BITS after LEAD_PAD
// leading pad bits and offers the result on a valid/ready stream. A sample
// that completes while the previous one is still pending is dropped and the
// sticky overrun flag is raised.
// Ports:
//   osc_clk       : sole clock, all logic on the rising edge
//   reset         : synchronous, active-high, overrides every other input
//   start         : single-shot frame request, only looked at in IDLE
//   continuous    : level, back-to-back frames while high
//   clear_overrun : clears the sticky overrun flag (a new drop wins)
//   overrun       : sticky, a completed sample was dropped
//   busy          : high whenever the FSM is not in IDLE
//   bus           : serial ADC bus plus sample stream (adc_sampler_if.master)
// ---------------------------------------------------------------------------
module adc_sampler #(
    parameter int CLK_DIV     = 64,
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_PAD    = 2,
    parameter int OUT_BITS    = 8,
    parameter int CONV_CYCLES = 1
) (
    input  logic          osc_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          continuous,
    input  logic          clear_overrun,
    output logic          overrun,
    output logic          busy,
    adc_sampler_if.master bus
);

    // Elaboration-time parameter sanity
    generate
        if (LEAD_PAD + OUT_BITS > FRAME_BITS) begin : g_bad_extract
            $error("adc_sampler: LEAD_PAD + OUT_BITS must not exceed FRAME_BITS");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("adc_sampler: CLK_DIV must be at least 1");
        end
        if (CONV_CYCLES < 1) begin : g_bad_conv
            $error("adc_sampler: CONV_CYCLES must be at least 1");
        end
        if (OUT_BITS < 1) begin : g_bad_out
            $error("adc_sampler: OUT_BITS must be at least 1");
        end
    endgenerate

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);
    localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0]  KEEP_LO   = BIT_W'(LEAD_PAD);
    localparam logic [BIT_W-1:0]  KEEP_END  = BIT_W'(LEAD_PAD + OUT_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [CONV_W-1:0]   conv_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [OUT_BITS-1:0] shift_r;
    logic                load_pend_r;
    logic                adc_clk_r;
    logic                adc_conv_r;
    logic [OUT_BITS-1:0] sample_data_r;
    logic                sample_valid_r;
    logic                overrun_r;
    logic                busy_r;

    logic                div_tick_s;
    logic                clk_rise_s;
    logic                clk_fall_s;
    logic                keep_bit_s;
    logic                accept_s;
    logic [OUT_BITS-1:0] shift_next_s;

    // The divider counter runs only in CONV/SHIFT; a tick toggles adc_clk,
    // so the edge about to happen is decided by the current adc_clk level.
    assign div_tick_s = (div_cnt_r == DIV_LAST);
    assign clk_rise_s = div_tick_s & ~adc_clk_r;
    assign clk_fall_s = div_tick_s &  adc_clk_r;

    // Only frame bits inside the extraction window are shifted in; the
    // window index is the count of bits already received in this frame.
    assign keep_bit_s = (bit_cnt_r >= KEEP_LO) && (bit_cnt_r < KEEP_END);

    // A finished frame is taken unless an undelivered sample is still held.
    assign accept_s = ~sample_valid_r | bus.sample_ready;

    generate
        if (OUT_BITS > 1) begin : g_shift_wide
            assign shift_next_s = {shift_r[OUT_BITS-2:0], bus.adc_data};
        end else begin : g_shift_one
            assign shift_next_s = bus.adc_data;
        end
    endgenerate

    // Sequencer FSM with divider, bit capture and output stream registers
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            div_cnt_r      <= {DIV_W{1'b0}};
            conv_cnt_r     <= {CONV_W{1'b0}};
            bit_cnt_r      <= {BIT_W{1'b0}};
            shift_r        <= {OUT_BITS{1'b0}};
            load_pend_r    <= 1'b0;
            adc_clk_r      <= 1'b0;
            adc_conv_r     <= 1'b0;
            sample_data_r  <= {OUT_BITS{1'b0}};
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            // Handshake retires the held sample; data stays as it was.
            if (sample_valid_r && bus.sample_ready) begin
                sample_valid_r <= 1'b0;
            end
            if (clear_overrun) begin
                overrun_r <= 1'b0;
            end
            // The sample accepted in DONE is published one edge later. The
            // shift register cannot change in between because the next
            // capture is at least one adc_clk half-period into SHIFT.
            load_pend_r <= 1'b0;
            if (load_pend_r) begin
                sample_data_r  <= shift_r;
                sample_valid_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    div_cnt_r  <= {DIV_W{1'b0}};
                    adc_clk_r  <= 1'b0;
                    adc_conv_r <= 1'b0;
                    busy_r     <= 1'b0;
                    if (start || continuous) begin
                        state_r    <= ST_CONV;
                        adc_conv_r <= 1'b1;
                        busy_r     <= 1'b1;
                        conv_cnt_r <= {CONV_W{1'b0}};
                        bit_cnt_r  <= {BIT_W{1'b0}};
                    end
                end

                ST_CONV: begin
                    if (div_tick_s) begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        adc_clk_r <= ~adc_clk_r;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                    // Each falling edge closes one adc_clk period.
                    if (clk_fall_s) begin
                        if (conv_cnt_r == CONV_LAST) begin
                            state_r    <= ST_SHIFT;
                            adc_conv_r <= 1'b0;
                            conv_cnt_r <= {CONV_W{1'b0}};
                        end else begin
                            conv_cnt_r <= conv_cnt_r + CONV_W'(1);
                        end
                    end
                end

                ST_SHIFT: begin
                    if (div_tick_s) begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        adc_clk_r <= ~adc_clk_r;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                    if (clk_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        if (keep_bit_s) begin
                            shift_r <= shift_next_s;
                        end
                    end
                    // The falling edge after the last rising edge ends the
                    // frame; the divider has just wrapped to 0 with adc_clk low.
                    if (clk_fall_s && (bit_cnt_r == BIT_LAST)) begin
                        state_r   <= ST_DONE;
                        bit_cnt_r <= {BIT_W{1'b0}};
                    end
                end

                ST_DONE: begin
                    div_cnt_r <= {DIV_W{1'b0}};
                    adc_clk_r <= 1'b0;
                    // A drop raises overrun after the clear above: set wins.
                    if (accept_s) begin
                        load_pend_r <= 1'b1;
                    end else begin
                        overrun_r <= 1'b1;
                    end
                    if (continuous) begin
                        state_r    <= ST_CONV;
                        adc_conv_r <= 1'b1;
                        conv_cnt_r <= {CONV_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    div_cnt_r  <= {DIV_W{1'b0}};
                    conv_cnt_r <= {CONV_W{1'b0}};
                    bit_cnt_r  <= {BIT_W{1'b0}};
                    adc_clk_r  <= 1'b0;
                    adc_conv_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_clk      = adc_clk_r;
    assign bus.adc_conv     = adc_conv_r;
    assign bus.sample_data  = sample_data_r;
    assign bus.sample_valid = sample_valid_r;
    assign overrun          = overrun_r;
    assign busy             = busy_r;

endmodule
